alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Two-stage registered execute stage wrapped around the team's combinational 32-bit ALU.
- Upstream decode issues operand/opcode/tag bundles with a valid/ready handshake.
- The stage latches operands, evaluates the ALU and registers the result and flags. It presents them to writeback through a second valid/ready handshake.
- It supports full-throughput streaming, backpressure with no data loss, and a synchronous flush.

Parameters:
- DATA_WIDTH, 32, operand/result width (ALU is fixed at 32; other values unsupported)
- TAG_WIDTH, 5, width of the sideband tag (destination register index)

Ports:
- clk  input  1  single clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous; kills all in-flight entries
- in_valid  input  1  request bundle valid
- in_ready  output  1  stage can accept this cycle
- in_a  input  DATA_WIDTH  operand A
- in_b  input  DATA_WIDTH  operand B
- in_op  input  3  ALUop: AND=000, OR=001, ADD=010, SUB=110, SLT=111
- in_tag  input  TAG_WIDTH  sideband, passed through unchanged
- out_valid  output  1  result bundle valid
- out_ready  input  1  consumer accepts this cycle
- out_result  output  DATA_WIDTH  ALU Result
- out_zero  output  1  Result == 0
- out_overflow  output  1  signed overflow; ADD/SUB only, else 0
- out_carry  output  1  ADD: carry-out; SUB: borrow (A <u B); else 0
- out_illegal  output  1  opcode not in the legal set
- out_tag  output  TAG_WIDTH  tag of this result

Behaviour:
- Reset (async, rst=1): s1_valid=0, s2_valid=0. All data registers are 0, so every output is 0 and in_ready=1 after reset.
- S1 (operand register): holds a, b, op, tag.
- ALU (combinational): sits between S1 and S2.
- S2 (result register): holds result, zero, overflow, carry, illegal, tag.
- Handshake: a transfer occurs when valid && ready on the same edge. Outputs are stable while out_valid && !out_ready.
- s2_adv = !s2_valid || out_ready.
- s1_adv = !s1_valid || s2_adv.
- in_ready = s1_adv. This is combinational from out_ready; a one-cycle bubble is not permitted.
- Latency: a bundle accepted at edge N is presented with out_valid=1 after edge N+1, assuming no stall.
- Throughput: 1 bundle per cycle.
- Ordering: strict FIFO, at most 2 entries in flight.
- S2 load: when s2_adv, S2 <= ALU(S1) and s2_valid <= s1_valid.
- S1 load: when s1_adv, S1 <= input bundle and s1_valid <= in_valid && in_ready.
- Full: both stages valid and out_ready=0 gives in_ready=0, with S1 and S2 holding.
- Drain: with out_ready=1 and in_valid=0, entries leave in order and valid bits clear.
- Arithmetic:
  - ADD/SUB use a 33-bit sum {cout,S} = A + B' + cin, with B' = ~B and cin = 1 for SUB.
  - overflow = (sign A == sign B') && (sign S != sign A).
  - SLT gives a signed less-than, result {31'b0, lt}. Overflow and carry are masked to 0 for SLT.
  - Illegal opcodes give result 0, zero=1, illegal=1, overflow=0, carry=0.
- Flush:
  - At the next edge, s1_valid=0 and s2_valid=0.
  - A bundle offered that same cycle is dropped, even though in_ready may be 1.
  - Data registers may keep stale values.
  - Flush takes priority over every load.
- Reset mid-operation: in-flight entries are lost and outputs go to 0 immediately, without waiting for a clock edge.

Optional Feature:
- ALU_STATS_EN defined: adds outputs stat_ops (32) and stat_ovf (32).
  - stat_ops counts every out handshake.
  - stat_ovf counts out handshakes with out_overflow=1.
  - Both wrap modulo 2^32, reset to 0, and are not cleared by flush.
- Not defined: the ports and counters are absent, with no other difference.

Decomposition:
- Shared package:
  - ALUop encodings (AND, OR, ADD, SUB, SLT).
  - DATA_WIDTH default.
  - Function is_legal_op.
  - Struct types for the S1 bundle and the S2 result bundle.
- One sub-module: instance of the existing combinational `alu`; flag masking and the illegal-op check are done in this stage.
- Pipeline control stays inline; no separate FSM module is needed.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, tag 3, out_ready=1: result 0x80000000, overflow=1, carry=0, zero=0, tag 3, two cycles after accept.
- SUB 0x00000000 − 0x00000001: result 0xFFFFFFFF, carry=1, overflow=0. Then SLT 0xFFFFFFFF vs 0x00000001: result 1, flags 0.
- out_ready=0, stream 3 ADDs (tags 1, 2, 3): tags 1 and 2 accepted, in_ready=0 on the third. Raise out_ready: tags 1, 2, 3 emerge in order on consecutive cycles.
- Opcode 011 with A=5, B=7: out_illegal=1, result 0, zero=1. Then AND 0xF0F0 & 0x0FF0 gives 0x00F0.
- Both stages full, assert flush together with a new in_valid: next cycle out_valid=0 and the new bundle is never emitted. Assert rst mid-stream: outputs 0 asynchronously, then the stage restarts cleanly.
- With ALU_STATS_EN: 10 handshakes, 2 of them overflowing: stat_ops=10, stat_ovf=2. A flush does not change them.

Source files
------------

// File: rtl/alu_exec_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_stage_pkg
//  Description : Shared definitions for the ALU execute stage: ALUop codes,
//                default widths, the legal-opcode check and the bundle
//                structs carried by the two pipeline registers.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_exec_stage_pkg;

    localparam int unsigned C_DATA_WIDTH_DEF = 32;
    localparam int unsigned C_TAG_WIDTH_DEF  = 5;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        logic legal;
        case (op)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Operand register contents. The opcode is kept as raw bits so that
    // illegal encodings survive into the result stage for flagging.
    typedef struct packed {
        logic [C_DATA_WIDTH_DEF-1:0] a;
        logic [C_DATA_WIDTH_DEF-1:0] b;
        logic [2:0]                  op;
    } s1_bundle_t;

    // Result register contents.
    typedef struct packed {
        logic [C_DATA_WIDTH_DEF-1:0] result;
        logic                        zero;
        logic                        overflow;
        logic                        carry;
        logic                        illegal;
    } s2_bundle_t;

endpackage : alu_exec_stage_pkg
`default_nettype wire

// File: rtl/alu_exec_stage_alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Combinational 32-bit ALU. op[2] inverts B and injects a
//                carry-in (subtract); op[1:0] selects AND / OR / SUM / SLT.
//                Raw carry-out and signed overflow are always produced; the
//                caller decides which opcodes expose them.
//  Ports       : a_i, b_i     - operands
//                op_i         - 3-bit ALU control
//                result_o     - selected result
//                cout_o       - carry out of the 33-bit sum
//                overflow_o   - signed overflow of the sum
//  Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_exec_stage_pkg::*;
(
    input  logic [C_DATA_WIDTH_DEF-1:0] a_i,
    input  logic [C_DATA_WIDTH_DEF-1:0] b_i,
    input  logic [2:0]                  op_i,
    output logic [C_DATA_WIDTH_DEF-1:0] result_o,
    output logic                        cout_o,
    output logic                        overflow_o
);

    logic [C_DATA_WIDTH_DEF-1:0] w_b_eff;
    logic [C_DATA_WIDTH_DEF:0]   w_sum;
    logic                        w_lt;

    assign w_b_eff = op_i[2] ? ~b_i : b_i;
    assign w_sum   = {1'b0, a_i} + {1'b0, w_b_eff}
                   + {{C_DATA_WIDTH_DEF{1'b0}}, op_i[2]};
    assign cout_o  = w_sum[C_DATA_WIDTH_DEF];

    assign overflow_o = (a_i[C_DATA_WIDTH_DEF-1] == w_b_eff[C_DATA_WIDTH_DEF-1])
                     && (w_sum[C_DATA_WIDTH_DEF-1] != a_i[C_DATA_WIDTH_DEF-1]);

    // Signed less-than: sign of A-B corrected by overflow.
    assign w_lt = w_sum[C_DATA_WIDTH_DEF-1] ^ overflow_o;

    always_comb begin
        result_o = '0;
        case (op_i[1:0])
            2'b00:   result_o = a_i & w_b_eff;
            2'b01:   result_o = a_i | w_b_eff;
            2'b10:   result_o = w_sum[C_DATA_WIDTH_DEF-1:0];
            default: result_o = {{(C_DATA_WIDTH_DEF-1){1'b0}}, w_lt};
        endcase
    end

endmodule : alu
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_stage
//  Description : Two-stage registered execute stage around the combinational
//                ALU. S1 latches operand bundles from decode, S2 latches the
//                ALU result and flags for writeback. Valid/ready on both
//                sides, full throughput, synchronous flush.
//  Ports       : clk, rst (async, active-high), flush
//                in_valid/in_ready, in_a, in_b, in_op, in_tag
//                out_valid/out_ready, out_result, out_zero, out_overflow,
//                out_carry, out_illegal, out_tag
//                stat_ops, stat_ovf (only with ALU_STATS_EN)
//  Config      : `define ALU_STATS_EN adds handshake / overflow counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = C_DATA_WIDTH_DEF,  // only 32 supported
    parameter int unsigned TAG_WIDTH  = C_TAG_WIDTH_DEF
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [2:0]            in_op,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_zero,
    output logic                  out_overflow,
    output logic                  out_carry,
    output logic                  out_illegal,
    output logic [TAG_WIDTH-1:0]  out_tag
`ifdef ALU_STATS_EN
    ,
    output logic [31:0]           stat_ops,
    output logic [31:0]           stat_ovf
`endif
);

    logic                 s1_valid_q;
    logic                 s2_valid_q;
    s1_bundle_t           s1_q;
    s1_bundle_t           s1_d;
    logic [TAG_WIDTH-1:0] s1_tag_q;
    s2_bundle_t           s2_q;
    s2_bundle_t           s2_d;
    logic [TAG_WIDTH-1:0] s2_tag_q;

    logic                        w_s2_adv;
    logic                        w_s1_adv;
    logic [C_DATA_WIDTH_DEF-1:0] w_alu_result;
    logic                        w_alu_cout;
    logic                        w_alu_ovf;

    // Ready chains back combinationally from out_ready so a draining
    // consumer never costs a bubble.
    assign w_s2_adv = !s2_valid_q || out_ready;
    assign w_s1_adv = !s1_valid_q || w_s2_adv;
    assign in_ready = w_s1_adv;

    assign s1_d = '{a: in_a, b: in_b, op: in_op};

    alu u_alu (
        .a_i        (s1_q.a),
        .b_i        (s1_q.b),
        .op_i       (s1_q.op),
        .result_o   (w_alu_result),
        .cout_o     (w_alu_cout),
        .overflow_o (w_alu_ovf)
    );

    // Flag masking: carry/overflow only mean something for ADD/SUB, and the
    // ALU reports a raw carry-out, so SUB borrow is its inverse.
    always_comb begin
        s2_d = '0;
        if (!is_legal_op(s1_q.op)) begin
            s2_d.zero    = 1'b1;
            s2_d.illegal = 1'b1;
        end else begin
            s2_d.result = w_alu_result;
            s2_d.zero   = (w_alu_result == '0);
            if (s1_q.op == OP_ADD) begin
                s2_d.overflow = w_alu_ovf;
                s2_d.carry    = w_alu_cout;
            end else if (s1_q.op == OP_SUB) begin
                s2_d.overflow = w_alu_ovf;
                s2_d.carry    = ~w_alu_cout;
            end
        end
    end

    // Data registers only load on a valid entry, so outputs stay quiet
    // during bubbles. Flush clears the valid bits and blocks every load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s1_tag_q   <= '0;
            s2_q       <= '0;
            s2_tag_q   <= '0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_q     <= s2_d;
                    s2_tag_q <= s1_tag_q;
                end
            end
            if (w_s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_q     <= s1_d;
                    s1_tag_q <= in_tag;
                end
            end
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_result   = s2_q.result;
    assign out_zero     = s2_q.zero;
    assign out_overflow = s2_q.overflow;
    assign out_carry    = s2_q.carry;
    assign out_illegal  = s2_q.illegal;
    assign out_tag      = s2_tag_q;

`ifdef ALU_STATS_EN
    logic [31:0] stat_ops_q;
    logic [31:0] stat_ovf_q;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops_q <= '0;
            stat_ovf_q <= '0;
        end else if (out_valid && out_ready) begin
            stat_ops_q <= stat_ops_q + 32'd1;
            if (out_overflow) begin
                stat_ovf_q <= stat_ovf_q + 32'd1;
            end
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_ovf = stat_ovf_q;
`endif

endmodule : alu_exec_stage
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec_stage
//  Description : Directed self-checking bench for alu_exec_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_op;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_overflow;
    logic        out_carry;
    logic        out_illegal;
    logic [4:0]  out_tag;
`ifdef ALU_STATS_EN
    logic [31:0] stat_ops;
    logic [31:0] stat_ovf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_exec_stage #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_op        (in_op),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
        .out_carry    (out_carry),
        .out_illegal  (out_illegal),
        .out_tag      (out_tag)
`ifdef ALU_STATS_EN
        ,
        .stat_ops     (stat_ops),
        .stat_ovf     (stat_ovf)
`endif
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [4:0] tag);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_tag   = tag;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({out_valid, out_result, out_zero, out_overflow, out_carry, out_illegal, out_tag} !== 42'd0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b res=%h tag=%0d, want all zero", out_valid, out_result, out_tag);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        rst = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0 || out_zero !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle: got valid=%b zero=%b want 0 0", out_valid, out_zero);
        end
    endtask

    task automatic test_add_overflow();
        out_ready = 1'b1;
        drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 5'd3);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL add_in_ready: got %b want 1", in_ready);
        end
        step();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL add_latency_early: got out_valid=%b want 0", out_valid);
        end
        step();
        total++;
        if ({out_valid, out_result, out_zero, out_overflow, out_carry, out_illegal, out_tag}
            !== {1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3}) begin
            bad++;
            $display("FAIL add_ovf: got v=%b res=%h z=%b o=%b c=%b i=%b tag=%0d want v=1 res=80000000 z=0 o=1 c=0 i=0 tag=3",
                     out_valid, out_result, out_zero, out_overflow, out_carry, out_illegal, out_tag);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL add_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_sub_slt();
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_0000, 32'h0000_0001, 3'b110, 5'd4);
        step();
        drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 5'd5);
        step();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
        total++;
        if ({out_valid, out_result, out_zero, out_overflow, out_carry, out_tag}
            !== {1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 5'd4}) begin
            bad++;
            $display("FAIL sub_borrow: got v=%b res=%h z=%b o=%b c=%b tag=%0d want v=1 res=ffffffff z=0 o=0 c=1 tag=4",
                     out_valid, out_result, out_zero, out_overflow, out_carry, out_tag);
        end
        step();
        total++;
        if ({out_valid, out_result, out_zero, out_overflow, out_carry, out_illegal, out_tag}
            !== {1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5}) begin
            bad++;
            $display("FAIL slt: got v=%b res=%h z=%b o=%b c=%b i=%b tag=%0d want v=1 res=00000001 flags 0 tag=5",
                     out_valid, out_result, out_zero, out_overflow, out_carry, out_illegal, out_tag);
        end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'd1, 32'd1, 3'b010, 5'd1);
        step();
        drive(1'b1, 32'd2, 32'd2, 3'b010, 5'd2);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_second_ready: got %b want 1", in_ready);
        end
        step();
        drive(1'b1, 32'd3, 32'd3, 3'b010, 5'd3);
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_full_ready: got %b want 0", in_ready);
        end
        step();
        total++;
        if ({out_valid, out_result, out_tag, in_ready} !== {1'b1, 32'd2, 5'd1, 1'b0}) begin
            bad++;
            $display("FAIL bp_hold: got v=%b res=%h tag=%0d rdy=%b want v=1 res=2 tag=1 rdy=0",
                     out_valid, out_result, out_tag, in_ready);
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_comb_ready: got %b want 1", in_ready);
        end
        step();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
        total++;
        if ({out_valid, out_result, out_tag} !== {1'b1, 32'd4, 5'd2}) begin
            bad++;
            $display("FAIL bp_order2: got v=%b res=%h tag=%0d want v=1 res=4 tag=2", out_valid, out_result, out_tag);
        end
        step();
        total++;
        if ({out_valid, out_result, out_tag} !== {1'b1, 32'd6, 5'd3}) begin
            bad++;
            $display("FAIL bp_order3: got v=%b res=%h tag=%0d want v=1 res=6 tag=3", out_valid, out_result, out_tag);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_empty: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_illegal_and();
        out_ready = 1'b1;
        drive(1'b1, 32'd5, 32'd7, 3'b011, 5'd7);
        step();
        drive(1'b1, 32'h0000_F0F0, 32'h0000_0FF0, 3'b000, 5'd8);
        step();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
        total++;
        if ({out_valid, out_result, out_zero, out_overflow, out_carry, out_illegal, out_tag}
            !== {1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7}) begin
            bad++;
            $display("FAIL illegal_op: got v=%b res=%h z=%b o=%b c=%b i=%b tag=%0d want v=1 res=0 z=1 o=0 c=0 i=1 tag=7",
                     out_valid, out_result, out_zero, out_overflow, out_carry, out_illegal, out_tag);
        end
        step();
        total++;
        if ({out_valid, out_result, out_zero, out_illegal, out_tag} !== {1'b1, 32'h0000_00F0, 1'b0, 1'b0, 5'd8}) begin
            bad++;
            $display("FAIL and_op: got v=%b res=%h z=%b i=%b tag=%0d want v=1 res=000000f0 z=0 i=0 tag=8",
                     out_valid, out_result, out_zero, out_illegal, out_tag);
        end
        step();
    endtask

    task automatic test_flush();
        int seen;
        out_ready = 1'b0;
        drive(1'b1, 32'd10, 32'd20, 3'b010, 5'd10);
        step();
        drive(1'b1, 32'd1, 32'd2, 3'b010, 5'd11);
        step();
        drive(1'b1, 32'd5, 32'd5, 3'b010, 5'd12);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_full: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (out_valid === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL flush_no_emit: got %0d emitted want 0", seen);
        end
        // Empty pipe, in_ready=1: the bundle offered with flush must vanish.
        drive(1'b1, 32'd9, 32'd9, 3'b010, 5'd14);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (out_valid === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL flush_drop_ready: got %0d emitted want 0", seen);
        end
        drive(1'b1, 32'd100, 32'd23, 3'b010, 5'd13);
        step();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
        step();
        total++;
        if ({out_valid, out_result, out_tag} !== {1'b1, 32'd123, 5'd13}) begin
            bad++;
            $display("FAIL flush_resume: got v=%b res=%h tag=%0d want v=1 res=7b tag=13", out_valid, out_result, out_tag);
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 32'h1234, 32'h1, 3'b010, 5'd20);
        step();
        drive(1'b1, 32'h5678, 32'h1, 3'b010, 5'd21);
        step();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, out_result, out_zero, out_tag, in_ready} !== {1'b0, 32'h0, 1'b0, 5'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_async: got v=%b res=%h z=%b tag=%0d rdy=%b want 0 0 0 0 1",
                     out_valid, out_result, out_zero, out_tag, in_ready);
        end
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        drive(1'b1, 32'd2, 32'd3, 3'b010, 5'd9);
        step();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL restart_no_stale: got out_valid=%b want 0", out_valid);
        end
        step();
        total++;
        if ({out_valid, out_result, out_tag} !== {1'b1, 32'd5, 5'd9}) begin
            bad++;
            $display("FAIL restart: got v=%b res=%h tag=%0d want v=1 res=5 tag=9", out_valid, out_result, out_tag);
        end
        step();
    endtask

`ifdef ALU_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3 || i == 7) drive(1'b1, 32'h7FFF_FFFF, 32'd1, 3'b010, 5'd1);
            else                  drive(1'b1, 32'd1, 32'd1, 3'b010, 5'd1);
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
        step();
        step();
        total++;
        if (stat_ops !== 32'd10 || stat_ovf !== 32'd2) begin
            bad++;
            $display("FAIL stats_count: got ops=%0d ovf=%0d want 10 2", stat_ops, stat_ovf);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        total++;
        if (stat_ops !== 32'd10 || stat_ovf !== 32'd2) begin
            bad++;
            $display("FAIL stats_flush: got ops=%0d ovf=%0d want 10 2", stat_ops, stat_ovf);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
        test_reset();
        test_add_overflow();
        test_sub_slt();
        test_backpressure();
        test_illegal_and();
        test_flush();
        test_reset_mid();
`ifdef ALU_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_exec_stage
`default_nettype wire
